fetch_unit: RTL

Instruction fetch stage for the pipelined hart. It replaces the combinational instruction port with a realistic request/response memory interface. It keeps up to DEPTH requests in flight and buffers returned words in an in-order queue. It presents {instruction, pc, trap} to decode over a valid/ready handshake, and flushes all buffered and in-flight fetches when a taken branch, jump or trap redirect arrives from execute.

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared RV fetch constants and buffer entry layout
package fetch_unit_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [31:0]       pc;
        logic              trap;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush (flush may load one new entry)
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy tracking; a flush restarts at slot 0 and may keep the pushed word.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= PTR_W'(push);
            count  <= CNT_W'(push);
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents are don't-care until the matching count covers them.
    always_ff @(posedge clk) begin
        if (flush) begin
            if (push) mem[0] <= wdata;
        end else if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - pipelined instruction fetch with ordered buffer and redirect flush (option: FETCH_MISALIGN_TRAP_EN)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h00000000,
    parameter int          DEPTH      = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_trap,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]        fetch_pc;
    logic [CNT_W-1:0]   drop_cnt;
    logic [CNT_W-1:0]   out_cnt;
    logic [CNT_W-1:0]   buf_count;
    logic [CNT_W:0]     occupancy;
    logic               halted;

    logic               pend_full;
    logic               pend_empty;
    logic [31:0]        pend_pc;

    logic               buf_full;
    logic               buf_empty;
    logic               buf_push;
    logic               buf_pop;
    logic [ENTRY_W-1:0] buf_rdata;
    fetch_entry_t       buf_wdata;
    fetch_entry_t       head;

    logic               accept;
    logic               resp;
    logic               keep_resp;
    logic [31:0]        target_pc;
    logic               target_trap;
    logic               unused_bits;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_pc   = i_redirect_pc;
    assign target_trap = (i_redirect_pc[1:0] != 2'b00);
    assign o_inst_trap = o_inst_valid && head.trap;
    assign unused_bits = ^{pend_full, buf_full};

    // Halt after a misaligned redirect until the next redirect arrives.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            halted <= 1'b0;
        end else if (i_redirect) begin
            halted <= target_trap;
        end
    end
`else
    assign target_pc   = {i_redirect_pc[31:2], 2'b00};
    assign target_trap = 1'b0;
    assign o_inst_trap = 1'b0;
    assign halted      = 1'b0;
    assign unused_bits = ^{pend_full, buf_full, i_redirect_pc[1:0], head.trap};
`endif

    // Every outstanding request has a reserved buffer slot, so the buffer can never overflow.
    assign occupancy  = {1'b0, out_cnt} + {1'b0, buf_count};
    assign o_mem_req  = i_rst_n && !halted && (occupancy < (CNT_W + 1)'(DEPTH));
    assign o_mem_addr = fetch_pc;

    assign accept    = o_mem_req && i_mem_ready;
    assign resp      = i_mem_valid && !pend_empty;
    assign keep_resp = resp && (drop_cnt == '0);

    assign buf_pop   = o_inst_valid && i_inst_ready;
    assign buf_push  = i_redirect ? target_trap : keep_resp;
    assign buf_wdata = i_redirect ? '{inst: NOP_INST, pc: target_pc, trap: 1'b1}
                                  : '{inst: i_mem_rdata, pc: pend_pc, trap: 1'b0};

    assign head         = fetch_entry_t'(buf_rdata);
    assign o_inst_valid = i_rst_n && !buf_empty;
    assign o_inst       = o_inst_valid ? head.inst : '0;
    assign o_inst_pc    = o_inst_valid ? head.pc   : '0;

    // Addresses of accepted requests; dropped responses still pop it, so it is never flushed.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pend_q (
        .clk    (i_clk),
        .resetn (i_rst_n),
        .push   (accept),
        .pop    (resp),
        .flush  (1'b0),
        .wdata  (fetch_pc),
        .rdata  (pend_pc),
        .count  (out_cnt),
        .full   (pend_full),
        .empty  (pend_empty)
    );

    // Decoded-side buffer; a redirect flushes it and may load a trap marker.
    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_inst_buf (
        .clk    (i_clk),
        .resetn (i_rst_n),
        .push   (buf_push),
        .pop    (buf_pop),
        .flush  (i_redirect),
        .wdata  (buf_wdata),
        .rdata  (buf_rdata),
        .count  (buf_count),
        .full   (buf_full),
        .empty  (buf_empty)
    );

    // Next fetch address and count of stale responses still to be discarded.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            fetch_pc <= RESET_ADDR;
            drop_cnt <= '0;
        end else if (i_redirect) begin
            fetch_pc <= target_pc;
            drop_cnt <= out_cnt + CNT_W'(accept) - CNT_W'(resp);
        end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
        end
    end

endmodule
